// File: rtl/bru_pkg.sv
// Shared constants for the execute-stage branch resolve unit:
// branch funct3 encodings, FSM state type and PC increment.
package bru_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } bru_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational branch condition decode: funct3 plus comparator flags
// give the taken decision and the unsigned-compare select.
module branch_cond_decode
    import bru_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       BrLt,
    input  logic       BrEq,
    output logic       taken,
    output logic       BrUn
);

    assign BrUn = (funct3 == BLTU) || (funct3 == BGEU);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            BEQ:         taken = BrEq;
            BNE:         taken = ~BrEq;
            BLT, BLTU:   taken = BrLt;
            BGE, BGEU:   taken = ~BrLt;
            // 010/011 are illegal encodings and never branch
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution for an always-taken predictor; issues a
// registered redirect and flush on mispredict. Optional counters: BRU_PERF_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    input  logic             stall_i,
    input  logic             is_branch_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic [Width-1:0] pc_i,
    input  logic [Width-1:0] imm_i,
    input  logic [Width-1:0] rs1_i,
    input  logic             BrLt_i,
    input  logic             BrEq_i,
    output logic             BrUn_o,
    output logic             redirect_valid_o,
    output logic [Width-1:0] redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    output logic [31:0]      br_cnt_o,
    output logic [31:0]      mispred_cnt_o
);

    bru_state_e       state_q;
    logic [Width-1:0] redirect_pc_q;
    logic [Width-1:0] target;
    logic             taken;
    logic             resolve;
    logic             mispred;
    logic             unused_jal;

    // JAL is predicted taken at fetch and never needs correcting here
    assign unused_jal = is_jal_i;

    branch_cond_decode u_cond (
        .funct3 (funct3_i),
        .BrLt   (BrLt_i),
        .BrEq   (BrEq_i),
        .taken  (taken),
        .BrUn   (BrUn_o)
    );

    assign resolve = ex_valid_i & ~stall_i & (state_q == IDLE);
    assign mispred = resolve & (is_jalr_i | (is_branch_i & ~taken));
    assign target  = is_jalr_i ? ((rs1_i + imm_i) & ~Width'(1))
                               : (pc_i + Width'(PC_INC));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispred) begin
                        state_q       <= REDIRECT;
                        redirect_pc_q <= target;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect_valid_o = (state_q == REDIRECT);
    assign flush_o          = (state_q == REDIRECT);
    assign redirect_pc_o    = redirect_pc_q;

`ifdef BRU_PERF_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve & is_branch_i) br_cnt_q <= br_cnt_q + 32'd1;
            if (mispred)               mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign br_cnt_o      = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against an
// operand-level reference model of redirect behaviour.
module tb_branch_resolve_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, stall_i;
    logic        is_branch_i, is_jal_i, is_jalr_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_i, imm_i, rs1_i;
    logic        BrLt_i, BrEq_i;
    logic        BrUn_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        flush_o;
    logic [31:0] br_cnt_o, mispred_cnt_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_busy;
    logic [31:0] m_pc;
    logic [31:0] m_br, m_mis;

    always #5 clk_i = ~clk_i;

    branch_resolve_unit #(.Width(32)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ex_valid_i       (ex_valid_i),
        .stall_i          (stall_i),
        .is_branch_i      (is_branch_i),
        .is_jal_i         (is_jal_i),
        .is_jalr_i        (is_jalr_i),
        .funct3_i         (funct3_i),
        .pc_i             (pc_i),
        .imm_i            (imm_i),
        .rs1_i            (rs1_i),
        .BrLt_i           (BrLt_i),
        .BrEq_i           (BrEq_i),
        .BrUn_o           (BrUn_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .br_cnt_o         (br_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // cls: 0 none, 1 branch, 2 jal, 3 jalr. a/b are the comparator operands.
    task automatic step(input bit v, input bit st, input int cls, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] a, input logic [31:0] b, input bit rdy, input bit rst);
        bit un, tk;
        @(negedge clk_i);
        un = (f3 == 3'd6) || (f3 == 3'd7);
        rst_ni           = ~rst;
        ex_valid_i       = v;
        stall_i          = st;
        is_branch_i      = (cls == 1);
        is_jal_i         = (cls == 2);
        is_jalr_i        = (cls == 3);
        funct3_i         = f3;
        pc_i             = pc;
        imm_i            = imm;
        rs1_i            = rs1;
        BrEq_i           = (a == b);
        BrLt_i           = un ? (a < b) : ($signed(a) < $signed(b));
        redirect_ready_i = rdy;
        #1 chk("brun", {31'd0, BrUn_o}, {31'd0, un});

        case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
        endcase
        if (rst) begin
            m_busy = 0; m_pc = 0; m_br = 0; m_mis = 0;
        end else if (m_busy) begin
            if (rdy) m_busy = 0;
        end else if (v && !st) begin
            if (cls == 1) m_br++;
            if (cls == 3) begin
                m_busy = 1; m_mis++; m_pc = (rs1 + imm) & 32'hFFFF_FFFE;
            end else if (cls == 1 && !tk) begin
                m_busy = 1; m_mis++; m_pc = pc + 32'd4;
            end
        end

        @(posedge clk_i);
        #1;
        chk("valid", {31'd0, redirect_valid_o}, {31'd0, m_busy});
        chk("flush", {31'd0, flush_o}, {31'd0, m_busy});
        chk("rpc", redirect_pc_o, m_pc);
`ifdef BRU_PERF_EN
        chk("brcnt", br_cnt_o, m_br);
        chk("miscnt", mispred_cnt_o, m_mis);
`else
        chk("brcnt", br_cnt_o, 32'd0);
        chk("miscnt", mispred_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        int cls;
        logic [31:0] a, b;
        m_busy = 0; m_pc = 0; m_br = 0; m_mis = 0;

        // reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_valid", {31'd0, redirect_valid_o}, 32'd0);
        chk("rst_pc", redirect_pc_o, 32'd0);

        // BEQ taken: no action
        step(1, 0, 1, 3'd0, 32'h100, 0, 0, 5, 5, 0, 0);
        chk("beq_taken_flush", {31'd0, flush_o}, 32'd0);

        // BNE not taken: redirect to pc+4, one cycle
        step(1, 0, 1, 3'd1, 32'h100, 0, 0, 5, 5, 1, 0);
        chk("bne_pc", redirect_pc_o, 32'h104);
        chk("bne_valid", {31'd0, redirect_valid_o}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("bne_drop", {31'd0, flush_o}, 32'd0);

        // BLTU not taken with ready held low; wrong-path BGE is ignored
        step(1, 0, 1, 3'd6, 32'h200, 0, 0, 9, 3, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 3'd5, 32'h300, 0, 0, 1, 7, 0, 0);
        chk("bltu_hold_pc", redirect_pc_o, 32'h204);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // JALR target with bit 0 cleared; JAL no action
        step(1, 0, 3, 3'd0, 32'h40, 32'h10, 32'h2001, 0, 0, 1, 0);
        chk("jalr_pc", redirect_pc_o, 32'h2010);
        step(1, 0, 2, 3'd0, 32'h50, 32'h80, 0, 0, 0, 1, 0);
        step(1, 0, 2, 3'd0, 32'h50, 32'h80, 0, 0, 0, 1, 0);
        chk("jal_none", {31'd0, redirect_valid_o}, 32'd0);

        // PC wrap
        step(1, 0, 1, 3'd0, 32'hFFFF_FFFC, 0, 0, 1, 2, 1, 0);
        chk("wrap_pc", redirect_pc_o, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // stalled mispredict resolves on first unstalled cycle
        step(1, 1, 1, 3'd1, 32'h500, 0, 0, 4, 4, 0, 0);
        step(1, 1, 1, 3'd1, 32'h500, 0, 0, 4, 4, 0, 0);
        chk("stall_none", {31'd0, redirect_valid_o}, 32'd0);
        step(1, 0, 1, 3'd1, 32'h500, 0, 0, 4, 4, 0, 0);
        chk("stall_pc", redirect_pc_o, 32'h504);

        // reset while in REDIRECT
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_redir", {31'd0, redirect_valid_o}, 32'd0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            cls = $urandom_range(0, 3);
            a = $urandom_range(0, 3) | ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0);
            b = $urandom_range(0, 3) | ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, cls,
                 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, a, b,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution for the always-taken pipeline. Drives `BrUn` to the branch comparator, consumes its `BrLt`/`BrEq`, and decides whether the fetch-stage prediction was correct. Conditional branches and JAL are predicted taken at fetch; JALR is never predicted. On a mispredict the block issues a registered redirect PC to fetch with a valid/ready handshake and flushes the younger pipeline stages until the redirect is accepted.

## Interface
- `Width`, 32: data/PC width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `ex_valid_i`  in  1  EX holds a valid instruction.
- `stall_i`  in  1  EX held this cycle; no resolution.
- `is_branch_i`, `is_jal_i`, `is_jalr_i`  in  1  one-hot instruction class; all 0 means non-control.
- `funct3_i`  in  3  branch condition.
- `pc_i`  in  Width  EX instruction PC.
- `imm_i`  in  Width  sign-extended immediate.
- `rs1_i`  in  Width  JALR base.
- `BrLt_i`, `BrEq_i`  in  1  comparator results.
- `BrUn_o`  out  1  unsigned compare select, combinational.
- `redirect_valid_o`  out  1  redirect request to fetch.
- `redirect_pc_o`  out  Width  redirect target.
- `redirect_ready_i`  in  1  fetch accepts the redirect.
- `flush_o`  out  1  kill IF/ID and ID/EX contents.
- `br_cnt_o`, `mispred_cnt_o`  out  32  performance counters.

## Operation
- `BrUn_o` = 1 when `funct3_i` is 110 or 111. Otherwise 0.
- Taken conditions by `funct3_i`:
  - 000: `BrEq`
  - 001: `!BrEq`
  - 100 and 110: `BrLt`
  - 101 and 111: `!BrLt`
  - 010 and 011: not taken (illegal encodings).
- Resolve event: `ex_valid_i & !stall_i` in state IDLE.
- Mispredict and redirect target:
  - Branch not taken: target = `pc_i + 4`.
  - JALR: always a mispredict; target = `(rs1_i + imm_i) & ~1`.
  - Taken branch, JAL, and non-control instructions: no action.
- Arithmetic is modulo 2^Width.
- FSM states IDLE and REDIRECT:
  - IDLE → REDIRECT on a resolve event that is a mispredict. On that edge, `redirect_pc_o` is loaded and `redirect_valid_o` and `flush_o` are set.
  - In REDIRECT: `redirect_valid_o` = 1, `flush_o` = 1, and `redirect_pc_o` is stable. EX inputs are ignored because they belong to the wrong path.
  - REDIRECT → IDLE on the edge where `redirect_ready_i` = 1. `redirect_valid_o` and `flush_o` are 0 the following cycle.
- Reset values: state IDLE, `redirect_valid_o` = 0, `redirect_pc_o` = 0, `flush_o` = 0, counters = 0.
- Reset asserted in REDIRECT drops the redirect at that edge.

## Timing
- Mispredict resolved in cycle N → `redirect_valid_o`/`flush_o` high in cycle N+1 (one-cycle registered latency).
- Ready sampled in cycle N+1 → back to IDLE in N+2; a new resolve is possible in N+2.
- `redirect_ready_i` may be high before valid; it is only sampled in REDIRECT.
- Minimum mispredict penalty: 2 cycles.
- `stall_i` with a mispredict in EX: no transition. Resolution occurs on the first unstalled cycle.
- `BrUn_o` is combinational from `funct3_i` and has no latency.

## Configuration
- `BRU_PERF_EN` defined:
  - `br_cnt_o` increments on every resolve event with `is_branch_i`.
  - `mispred_cnt_o` increments on every IDLE→REDIRECT transition.
  - Both are 32-bit wrapping counters, cleared by reset.
- Not defined: both outputs are tied to 0 and no counter flops exist.

## Structure
- `bru_pkg` holds:
  - the `funct3` localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - the `bru_state_e` enum {IDLE, REDIRECT};
  - the PC increment constant 4.
- Sub-module `branch_cond_decode` is combinational: (`funct3`, `BrLt`, `BrEq`) → (`taken`, `BrUn`).
- The FSM, target adders and counters live in the top module.

## Test plan
- BEQ with `BrEq`=1, `pc_i`=0x100 → no redirect and no flush; `br_cnt_o` +1 with `BRU_PERF_EN`.
- BNE with `BrEq`=1, `pc_i`=0x100, `redirect_ready_i`=1 → in the next cycle `redirect_valid_o`=1, `redirect_pc_o`=0x104 and `flush_o`=1 for one cycle; `mispred_cnt_o`=1.
- BLTU, `funct3`=110 → `BrUn_o`=1. `redirect_ready_i` held 0 for 3 cycles → valid and flush stay high 4 cycles with PC stable; a mispredicting BGE presented meanwhile is ignored.
- JALR with `rs1_i`=0x2001, `imm_i`=0x10 → `redirect_pc_o`=0x2010. JAL → no redirect.
- `pc_i`=0xFFFFFFFC with a not-taken BEQ → `redirect_pc_o`=0x00000000 (wrap). Mispredict with `stall_i`=1 for 2 cycles → redirect appears the cycle after stall drops.
- `rst_ni`=0 while in REDIRECT → next cycle `redirect_valid_o`=0, `flush_o`=0, counters=0, state IDLE.
